// File: rtl/axi_rd_sched_pkg.sv
// Shared types and round-robin helper for the AXI read ID scheduler.
// Optional per-ID read timeout is enabled by defining RD_TIMEOUT_EN.
package axi_rd_sched_pkg;

  localparam int ID_W   = 2;
  localparam int SEQ_W  = 4;
  localparam int NUM_ID = 1 << ID_W;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [ID_W-1:0]  id;
  } arid_t;

  function automatic logic [NUM_ID-1:0] rr_pick(
    input logic [NUM_ID-1:0] req,
    input logic [ID_W-1:0]   ptr
  );
    logic [NUM_ID-1:0] gnt;
    logic [ID_W-1:0]   idx;
    logic              found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_ID; k++) begin
      idx = ptr + ID_W'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rd_id_out_counter.sv
// Per-ID issue sequence and outstanding-burst counter.
// Defining RD_TIMEOUT_EN adds a saturating no-progress timer.
module rd_id_out_counter #(
  parameter int SEQ_W = 4
`ifdef RD_TIMEOUT_EN
  ,
  parameter int TO_W  = 10
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             issue,
  input  logic             complete,
  output logic [SEQ_W-1:0] seq,
  output logic             full,
  output logic             zero,
  output logic             timeout
);

  logic [SEQ_W:0]   cnt_q;
  logic [SEQ_W-1:0] seq_q;

  assign seq  = seq_q;
  assign full = cnt_q[SEQ_W];
  assign zero = (cnt_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_q <= '0;
      cnt_q <= '0;
    end else begin
      if (issue)
        seq_q <= seq_q + SEQ_W'(1);
      // a completion against zero is an error, not an underflow
      unique case (1'b1)
        (issue && !complete):
          cnt_q <= cnt_q + (SEQ_W+1)'(1);
        (complete && !issue && !zero):
          cnt_q <= cnt_q - (SEQ_W+1)'(1);
        default: ;
      endcase
    end
  end

`ifdef RD_TIMEOUT_EN
  logic [TO_W-1:0] tmr_q;
  logic [TO_W-1:0] tmr_d;
  logic            to_q;

  always_comb begin
    tmr_d = tmr_q;
    if (complete || zero)
      tmr_d = '0;
    else if (!(&tmr_q))
      tmr_d = tmr_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_q <= '0;
      to_q  <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      to_q  <= to_q | (&tmr_d);
    end
  end

  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/axi_rd_id_scheduler.sv
// Round-robin AR channel sharing with per-ID sequence tagging and throttling.
// Optional per-ID read timeout is enabled by defining RD_TIMEOUT_EN.
module axi_rd_id_scheduler
  import axi_rd_sched_pkg::*;
#(
  parameter int ID_W   = axi_rd_sched_pkg::ID_W,
  parameter int SEQ_W  = axi_rd_sched_pkg::SEQ_W,
  parameter int ADDR_W = 32
`ifdef RD_TIMEOUT_EN
  ,
  parameter int TO_W   = 10
`endif
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2**ID_W-1:0]       req_valid,
  input  logic [2**ID_W*ADDR_W-1:0] req_addr,
  input  logic [2**ID_W*8-1:0]     req_len,
  output logic [2**ID_W-1:0]       req_ready,
  output logic                     ARVALID,
  input  logic                     ARREADY,
  output logic [ID_W+SEQ_W-1:0]    ARID,
  output logic [ADDR_W-1:0]        ARADDR,
  output logic [7:0]               ARLEN,
  input  logic                     RVALID,
  input  logic                     RREADY,
  input  logic                     RLAST,
  input  logic [ID_W+SEQ_W-1:0]    RID,
  output logic                     idle,
  output logic                     rsp_err,
  output logic [2**ID_W-1:0]       rd_timeout
);

  localparam int N_ID = 2**ID_W;

  logic [N_ID-1:0]            full;
  logic [N_ID-1:0]            zero;
  logic [N_ID-1:0]            elig;
  logic [N_ID-1:0]            grant;
  logic [N_ID-1:0]            complete;
  logic [N_ID-1:0]            to_flag;
  logic [N_ID-1:0][SEQ_W-1:0] seq;

  logic              slot_free;
  logic              cpl;
  logic [ID_W-1:0]   cpl_id;
  logic [SEQ_W-1:0]  unused_rid_seq;
  logic [ID_W-1:0]   gnt_idx;
  logic [ADDR_W-1:0] gnt_addr;
  logic [7:0]        gnt_len;
  logic [ID_W-1:0]   rr_ptr;

  logic              ar_valid_q;
  arid_t             ar_id_q;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [7:0]        ar_len_q;
  logic              rsp_err_q;

  assign elig      = req_valid & ~full;
  assign slot_free = !ar_valid_q || ARREADY;
  assign grant     = slot_free ? rr_pick(elig, rr_ptr) : '0;
  assign req_ready = grant;

  always_comb begin
    gnt_idx  = '0;
    gnt_addr = '0;
    gnt_len  = '0;
    for (int i = 0; i < N_ID; i++) begin
      if (grant[i]) begin
        gnt_idx  = ID_W'(i);
        gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
        gnt_len  = req_len[i*8 +: 8];
      end
    end
  end

  // the RID seq field belongs to the R-side trackers
  assign cpl            = RVALID && RREADY && RLAST;
  assign cpl_id         = RID[ID_W-1:0];
  assign unused_rid_seq = RID[ID_W+SEQ_W-1:ID_W];
  assign complete       = cpl ? (N_ID'(1) << cpl_id) : '0;

  for (genvar i = 0; i < N_ID; i++) begin : g_cnt
    rd_id_out_counter #(
      .SEQ_W (SEQ_W)
`ifdef RD_TIMEOUT_EN
      ,
      .TO_W  (TO_W)
`endif
    ) u_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .issue    (grant[i]),
      .complete (complete[i]),
      .seq      (seq[i]),
      .full     (full[i]),
      .zero     (zero[i]),
      .timeout  (to_flag[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ar_valid_q <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      rr_ptr     <= '0;
    end else if (slot_free) begin
      ar_valid_q <= |grant;
      if (|grant) begin
        ar_id_q.seq <= seq[gnt_idx];
        ar_id_q.id  <= gnt_idx;
        ar_addr_q   <= gnt_addr;
        ar_len_q    <= gnt_len;
        rr_ptr      <= gnt_idx + ID_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rsp_err_q <= 1'b0;
    else if (cpl && zero[cpl_id])
      rsp_err_q <= 1'b1;
  end

  assign ARVALID    = ar_valid_q;
  assign ARID       = ar_id_q;
  assign ARADDR     = ar_addr_q;
  assign ARLEN      = ar_len_q;
  assign idle       = !ar_valid_q && (&zero);
  assign rsp_err    = rsp_err_q;
  assign rd_timeout = to_flag;

endmodule

// File: tb/tb_axi_rd_id_scheduler.sv
// Directed and random checks of axi_rd_id_scheduler against a behavioural model.
// Timeout checks are included when RD_TIMEOUT_EN is defined.
module tb_axi_rd_id_scheduler;

  localparam int ID_W  = 2;
  localparam int SEQ_W = 4;
  localparam int AW    = 32;
  localparam int N     = 4;
  localparam int MAXO  = 16;
`ifdef RD_TIMEOUT_EN
  localparam int TO_W  = 10;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*8-1:0]    req_len;
  logic [N-1:0]      req_ready;
  logic              ARVALID;
  logic              ARREADY;
  logic [5:0]        ARID;
  logic [AW-1:0]     ARADDR;
  logic [7:0]        ARLEN;
  logic              RVALID;
  logic              RREADY;
  logic              RLAST;
  logic [5:0]        RID;
  logic              idle;
  logic              rsp_err;
  logic [N-1:0]      rd_timeout;

  always #5 clk = ~clk;

  axi_rd_id_scheduler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_ready  (req_ready),
    .ARVALID    (ARVALID),
    .ARREADY    (ARREADY),
    .ARID       (ARID),
    .ARADDR     (ARADDR),
    .ARLEN      (ARLEN),
    .RVALID     (RVALID),
    .RREADY     (RREADY),
    .RLAST      (RLAST),
    .RID        (RID),
    .idle       (idle),
    .rsp_err    (rsp_err),
    .rd_timeout (rd_timeout)
  );

  int checks = 0;
  int errors = 0;

  // reference model: AR slot contents, pointer, per-ID counts
  bit        m_arv;
  int        m_arid;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  int        m_ptr;
  int        m_cnt[N];
  int        m_seq[N];
  bit        m_err;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    int idx;
    if (m_arv && !ARREADY) return -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (req_valid[idx] && m_cnt[idx] < MAXO) return idx;
    end
    return -1;
  endfunction

  function automatic bit exp_idle();
    if (m_arv) return 1'b0;
    for (int i = 0; i < N; i++)
      if (m_cnt[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_arv  = 0;
    m_arid = 0;
    m_addr = '0;
    m_len  = '0;
    m_ptr  = 0;
    m_err  = 0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_seq[i] = 0;
    end
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    RREADY    = 1'b0;
    RLAST     = 1'b0;
    RID       = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    model_reset();
    #1 reset_n = 1'b1;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = $urandom;
      req_len[i*8 +: 8]    = 8'($urandom);
    end
  endtask

  task automatic complete_rid(input logic [5:0] rid);
    RVALID = 1'b1;
    RREADY = 1'b1;
    RLAST  = 1'b1;
    RID    = rid;
  endtask

  task automatic no_r();
    RVALID = 1'b0;
    RREADY = 1'b0;
    RLAST  = 1'b0;
  endtask

  // one clock: check outputs mid-cycle, then advance the model
  task automatic step();
    int   g;
    int   c;
    bit   cpl;
    logic [N-1:0] er;
    @(negedge clk);
    g  = exp_grant();
    er = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", req_ready, er);
    chk("arvalid", ARVALID, m_arv);
    chk("arid", ARID, m_arid);
    chk("araddr", ARADDR, m_addr);
    chk("arlen", ARLEN, m_len);
    chk("idle", idle, exp_idle());
    chk("rsp_err", rsp_err, m_err);
`ifndef RD_TIMEOUT_EN
    chk("rd_timeout", rd_timeout, 0);
`endif
    @(posedge clk);
    if (!m_arv || ARREADY) begin
      if (g >= 0) begin
        m_arv    = 1;
        m_arid   = (m_seq[g] << ID_W) | g;
        m_addr   = req_addr[g*AW +: AW];
        m_len    = req_len[g*8 +: 8];
        m_seq[g] = (m_seq[g] + 1) % MAXO;
        m_ptr    = (g + 1) % N;
      end else begin
        m_arv = 0;
      end
    end
    cpl = RVALID && RREADY && RLAST;
    c   = int'(RID) % N;
    if (cpl && m_cnt[c] == 0) m_err = 1;
    if (!(g >= 0 && cpl && c == g)) begin
      if (g >= 0) m_cnt[g]++;
      if (cpl && m_cnt[c] > 0) m_cnt[c]--;
    end
    #1;
  endtask

  int          t2_arid[5];
  logic [5:0]  cap_id;
  logic [31:0] cap_addr;
  logic [7:0]  cap_len;

  initial begin
    reset_n = 1'b1;
    clear_inputs();
    #1;
    do_reset();

    // reset state, no traffic
    chk("rst_idle", idle, 1);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_to", rd_timeout, 0);
    chk("rst_arid", ARID, 0);
    repeat (3) step();

    // all requesting, slot always free: 0,1,2,3,0
    t2_arid = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04};
    req_valid = 4'b1111;
    ARREADY   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_payload();
      step();
      chk("b2b_arid", ARID, t2_arid[i]);
      chk("b2b_valid", ARVALID, 1);
    end

    // stall: AR must hold, no grants
    ARREADY  = 1'b0;
    cap_id   = ARID;
    cap_addr = ARADDR;
    cap_len  = ARLEN;
    for (int i = 0; i < 5; i++) begin
      rand_payload();
      step();
      chk("stall_arid", ARID, cap_id);
      chk("stall_addr", ARADDR, cap_addr);
      chk("stall_len", ARLEN, cap_len);
      chk("stall_ready", req_ready, 0);
    end
    ARREADY = 1'b1;
    step();
    chk("unstall_arid", ARID, 6'h05);

    // throttle at 16 outstanding, then wrap
    do_reset();
    req_valid = 4'b0010;
    ARREADY   = 1'b1;
    for (int i = 0; i < MAXO; i++) begin
      rand_payload();
      step();
    end
    chk("full_ready", req_ready[1], 0);
    step();
    chk("full_ready2", req_ready[1], 0);
    complete_rid(6'h01);
    step();
    no_r();
    chk("regrant_ready", req_ready[1], 1);
    step();
    chk("wrap_arid", ARID, 6'h01);

    // same-cycle issue+complete, then error on empty ID
    do_reset();
    ARREADY   = 1'b1;
    req_valid = 4'b0100;
    step();
    complete_rid(6'h02);
    step();
    req_valid = '0;
    step();
    no_r();
    step();
    chk("same_err", rsp_err, 0);
    chk("same_idle", idle, 1);
    complete_rid(6'h03);
    step();
    no_r();
    chk("empty_err", rsp_err, 1);
    step();

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      req_valid = 4'($urandom);
      ARREADY   = ($urandom_range(0, 3) != 0);
      RVALID    = 1'($urandom);
      RREADY    = 1'($urandom);
      RLAST     = 1'($urandom);
      RID       = 6'($urandom);
      rand_payload();
      step();
    end
    clear_inputs();
    step();

`ifdef RD_TIMEOUT_EN
    // one outstanding on ID0, no response
    do_reset();
    ARREADY   = 1'b1;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    for (int i = 0; i < (1 << TO_W) - 2; i++) step();
    chk("to_before", rd_timeout, 0);
    step();
    chk("to_set", rd_timeout, 4'b0001);
    repeat (3) step();
    chk("to_sticky", rd_timeout, 4'b0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
